hilo_div_ctrl: RTL and testbench



---
 rtl/hilo_div_ctrl_pkg.sv | 28 ++
 rtl/hilo_div_ctrl.sv | 179 +++++++++++++++++
 tb/tb_hilo_div_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_div_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hilo_div_ctrl_pkg
// Brief   : Shared types and constants for the HI/LO divide controller.
// Revision: 1.0 - initial release
// ============================================================================
package hilo_div_ctrl_pkg;

    // Controller states: waiting, divider running, waiting for ready to drop,
    // and annulling a cancelled or timed-out divide.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ABORT = 2'd3
    } div_state_t;

    // Number of cycles the annul strobe is held after a cancel or timeout.
    localparam int DIV_ABORT_CYCLES = 3;

    // Number of BUSY cycles without a ready before the watchdog fires.
    localparam int DIV_TIMEOUT      = 48;

    localparam int BUSY_CNT_W       = 6;
    localparam int ABORT_CNT_W      = 2;

endpackage : hilo_div_ctrl_pkg
`default_nettype wire

// File: rtl/hilo_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hilo_div_ctrl
// Brief   : Sequences a pipeline DIV/DIVU request through an external
//           multi-cycle divider and writes the result into HI/LO.
// Revision: 1.0 - initial release
// ============================================================================
module hilo_div_ctrl
    import hilo_div_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,            // asynchronous, active-low
    // pipeline side
    input  logic        req_valid,
    input  logic        req_signed,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    input  logic        flush,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        done_o,
    output logic        timeout_o,
    // divider side
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i
);

    localparam logic [BUSY_CNT_W-1:0]  c_busy_last  = BUSY_CNT_W'(DIV_TIMEOUT - 1);
    localparam logic [ABORT_CNT_W-1:0] c_abort_last = ABORT_CNT_W'(DIV_ABORT_CYCLES - 1);

    div_state_t             r_state;
    div_state_t             w_next_state;
    logic [BUSY_CNT_W-1:0]  r_busy_cnt;
    logic [ABORT_CNT_W-1:0] r_abort_cnt;

    logic                   w_accept;
    logic                   w_capture;
    logic                   w_timeout_hit;

    logic [31:0]            r_hi;
    logic [31:0]            r_lo;
    logic                   r_done;
    logic                   r_timeout;
    logic                   r_div_signed;
    logic [31:0]            r_div_op1;
    logic [31:0]            r_div_op2;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; flush outranks a same-cycle ready, ready outranks
    // the watchdog so a result arriving on the last allowed cycle is kept.
    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_capture     = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    w_next_state = ST_ABORT;
                end else if (div_ready_i) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_DRAIN;
                end else if (r_busy_cnt == c_busy_last) begin
                    w_timeout_hit = 1'b1;
                    w_next_state  = ST_ABORT;
                end
            end
            ST_DRAIN: begin
                if (!div_ready_i) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ABORT: begin
                if (r_abort_cnt == c_abort_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Cycle counters: BUSY watchdog and ABORT length.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy_cnt  <= '0;
            r_abort_cnt <= '0;
        end else begin
            if (r_state == ST_BUSY) begin
                r_busy_cnt <= r_busy_cnt + BUSY_CNT_W'(1);
            end else if (w_accept) begin
                r_busy_cnt <= '0;
            end

            if (r_state == ST_ABORT) begin
                r_abort_cnt <= r_abort_cnt + ABORT_CNT_W'(1);
            end else begin
                r_abort_cnt <= '0;
            end
        end
    end

    // Divider operands are captured once on acceptance and held until IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_signed <= 1'b0;
            r_div_op1    <= '0;
            r_div_op2    <= '0;
        end else if (w_accept) begin
            r_div_signed <= req_signed;
            r_div_op1    <= req_op1;
            r_div_op2    <= req_op2;
        end
    end

    // Architectural HI/LO update and the one-cycle completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_capture;
            if (w_capture) begin
                r_hi <= div_result_i[63:32];
                r_lo <= div_result_i[31:0];
            end
        end
    end

    // Sticky watchdog flag; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timeout <= 1'b0;
        end else if (w_timeout_hit) begin
            r_timeout <= 1'b1;
        end
    end

    // Divider strobes come straight from the state register, so no
    // pipeline input reaches the divider combinationally.
    assign div_start_o  = (r_state == ST_BUSY);
    assign div_annul_o  = (r_state == ST_ABORT);
    assign div_signed_o = r_div_signed;
    assign div_op1_o    = r_div_op1;
    assign div_op2_o    = r_div_op2;

    // The stall drops in the capture cycle so the instruction retires
    // together with the HI/LO write.
    assign stall_o   = ~flush & req_valid & ~((r_state == ST_BUSY) & div_ready_i);

    assign hi_o      = r_hi;
    assign lo_o      = r_lo;
    assign done_o    = r_done;
    assign timeout_o = r_timeout;

endmodule : hilo_div_ctrl
`default_nettype wire

// File: tb/tb_hilo_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_hilo_div_ctrl
// Brief   : Directed self-checking bench for hilo_div_ctrl; the divider is
//           played by the bench, which supplies hand-computed results.
// Revision: 1.0 - initial release
// ============================================================================
module tb_hilo_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_signed;
    logic [31:0] req_op1;
    logic [31:0] req_op2;
    logic        flush;
    logic        stall_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        done_o;
    logic        timeout_o;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    hilo_div_ctrl u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_signed   (req_signed),
        .req_op1      (req_op1),
        .req_op2      (req_op2),
        .flush        (flush),
        .stall_o      (stall_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .done_o       (done_o),
        .timeout_o    (timeout_o),
        .div_start_o  (div_start_o),
        .div_annul_o  (div_annul_o),
        .div_signed_o (div_signed_o),
        .div_op1_o    (div_op1_o),
        .div_op2_o    (div_op2_o),
        .div_result_i (div_result_i),
        .div_ready_i  (div_ready_i)
    );

    always #5 clk = ~clk;

    // Count completion pulses, sampled away from the rising edge.
    always @(negedge clk) begin
        if (done_o === 1'b1) done_cnt++;
    end

    // Present a request on the next falling edge.
    task automatic drive_req(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid  = 1'b1;
        req_signed = sgn;
        req_op1    = a;
        req_op2    = b;
    endtask

    // Advance n falling edges, counting those with div_start_o high.
    task automatic busy_wait(input int n, output int starts);
        starts = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (div_start_o === 1'b1) starts++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_signed = 1'b0; req_op1 = '0; req_op2 = '0;
        flush = 1'b0; div_ready_i = 1'b0; div_result_i = '0;
        #1 rst = 1'b0;
        #1;
        checks++; if (hi_o !== 32'd0) begin errors++; $display("FAIL rst_hi got %0h exp 0", hi_o); end
        checks++; if (lo_o !== 32'd0) begin errors++; $display("FAIL rst_lo got %0h exp 0", lo_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL rst_done got %0b exp 0", done_o); end
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL rst_timeout got %0b exp 0", timeout_o); end
        checks++; if (div_start_o !== 1'b0 || div_annul_o !== 1'b0) begin errors++; $display("FAIL rst_strobes got start=%0b annul=%0b exp 0 0", div_start_o, div_annul_o); end
        checks++; if (div_signed_o !== 1'b0 || div_op1_o !== 32'd0 || div_op2_o !== 32'd0) begin errors++; $display("FAIL rst_ops got %0b %0h %0h exp 0 0 0", div_signed_o, div_op1_o, div_op2_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b exp 0", stall_o); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_divu();
        int st;
        int d0;
        d0 = done_cnt;
        drive_req(1'b0, 32'd100, 32'd7);
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL divu_stall_idle got %0b exp 1", stall_o); end
        busy_wait(35, st);
        checks++; if (div_op1_o !== 32'd100 || div_op2_o !== 32'd7 || div_signed_o !== 1'b0) begin errors++; $display("FAIL divu_ops got %0h %0h %0b exp 64 7 0", div_op1_o, div_op2_o, div_signed_o); end
        div_ready_i  = 1'b1;
        div_result_i = {32'd2, 32'd14};
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL divu_stall_capture got %0b exp 0", stall_o); end
        @(negedge clk);
        req_valid    = 1'b0;
        div_result_i = 64'hDEAD_BEEF_0BAD_F00D;
        #1;
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL divu_done got %0b exp 1", done_o); end
        checks++; if (lo_o !== 32'd14 || hi_o !== 32'd2) begin errors++; $display("FAIL divu_hilo got hi=%0h lo=%0h exp hi=2 lo=e", hi_o, lo_o); end
        @(negedge clk);
        div_ready_i = 1'b0;
        #1;
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL divu_done_pulse got %0b exp 0", done_o); end
        checks++; if (lo_o !== 32'd14 || hi_o !== 32'd2) begin errors++; $display("FAIL divu_drain_ignore got hi=%0h lo=%0h exp hi=2 lo=e", hi_o, lo_o); end
        @(negedge clk);
        #2;
        checks++; if (st !== 35) begin errors++; $display("FAIL divu_start_cycles got %0d exp 35", st); end
        checks++; if (div_start_o !== 1'b0) begin errors++; $display("FAIL divu_idle_start got %0b exp 0", div_start_o); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL divu_done_count got %0d exp 1", done_cnt - d0); end
    endtask

    task automatic test_divzero();
        int st;
        drive_req(1'b1, 32'd5, 32'd0);
        busy_wait(6, st);
        div_ready_i  = 1'b1;
        div_result_i = 64'd0;
        @(negedge clk);
        req_valid   = 1'b0;
        div_ready_i = 1'b0;
        #1;
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL divzero_done got %0b exp 1", done_o); end
        checks++; if (hi_o !== 32'd0 || lo_o !== 32'd0) begin errors++; $display("FAIL divzero_hilo got hi=%0h lo=%0h exp 0 0", hi_o, lo_o); end
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL divzero_timeout got %0b exp 0", timeout_o); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_signed();
        int st;
        drive_req(1'b1, 32'hFFFF_FFF9, 32'd2);
        busy_wait(10, st);
        checks++; if (div_signed_o !== 1'b1 || div_op1_o !== 32'hFFFF_FFF9) begin errors++; $display("FAIL div_signed_ops got %0b %0h exp 1 fffffff9", div_signed_o, div_op1_o); end
        div_ready_i  = 1'b1;
        div_result_i = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        @(negedge clk);
        req_valid   = 1'b0;
        div_ready_i = 1'b0;
        #1;
        checks++; if (lo_o !== 32'hFFFF_FFFD || hi_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_signed_hilo got hi=%0h lo=%0h exp ffffffff fffffffd", hi_o, lo_o); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_flush();
        int st;
        int an;
        int d0;
        d0 = done_cnt;
        drive_req(1'b0, 32'd123, 32'd4);
        busy_wait(10, st);
        flush        = 1'b1;
        div_ready_i  = 1'b1;
        div_result_i = {32'd3, 32'd30};
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_stall got %0b exp 0", stall_o); end
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        an = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            if (div_annul_o === 1'b1) an++;
        end
        div_ready_i = 1'b0;
        #2;
        checks++; if (an !== 3) begin errors++; $display("FAIL flush_annul_cycles got %0d exp 3", an); end
        checks++; if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFD) begin errors++; $display("FAIL flush_hilo_kept got hi=%0h lo=%0h exp ffffffff fffffffd", hi_o, lo_o); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL flush_no_done got %0d exp 0", done_cnt - d0); end
        drive_req(1'b0, 32'd9, 32'd3);
        busy_wait(4, st);
        div_ready_i  = 1'b1;
        div_result_i = {32'd0, 32'd3};
        @(negedge clk);
        req_valid   = 1'b0;
        div_ready_i = 1'b0;
        #1;
        checks++; if (lo_o !== 32'd3 || hi_o !== 32'd0) begin errors++; $display("FAIL flush_next_hilo got hi=%0h lo=%0h exp 0 3", hi_o, lo_o); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int st;
        int an;
        int d0;
        d0 = done_cnt;
        drive_req(1'b0, 32'd50, 32'd5);
        div_ready_i = 1'b0;
        busy_wait(48, st);
        checks++; if (st !== 48) begin errors++; $display("FAIL timeout_busy_cycles got %0d exp 48", st); end
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL timeout_early got %0b exp 0", timeout_o); end
        @(negedge clk);
        #1;
        checks++; if (timeout_o !== 1'b1) begin errors++; $display("FAIL timeout_flag got %0b exp 1", timeout_o); end
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL timeout_abort_stall got %0b exp 1", stall_o); end
        an = (div_annul_o === 1'b1) ? 1 : 0;
        req_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (div_annul_o === 1'b1) an++;
        end
        #2;
        checks++; if (an !== 3) begin errors++; $display("FAIL timeout_annul_cycles got %0d exp 3", an); end
        checks++; if (timeout_o !== 1'b1 || div_start_o !== 1'b0) begin errors++; $display("FAIL timeout_sticky_idle got to=%0b start=%0b exp 1 0", timeout_o, div_start_o); end
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL timeout_no_done got %0d exp 0", done_cnt - d0); end
        rst = 1'b0;
        #1;
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL timeout_reset_clear got %0b exp 0", timeout_o); end
        checks++; if (hi_o !== 32'd0 || lo_o !== 32'd0) begin errors++; $display("FAIL timeout_reset_hilo got hi=%0h lo=%0h exp 0 0", hi_o, lo_o); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_back_to_back();
        int st;
        int d0;
        d0 = done_cnt;
        drive_req(1'b0, 32'd10, 32'd3);
        busy_wait(3, st);
        div_ready_i  = 1'b1;
        div_result_i = {32'd1, 32'd3};
        @(negedge clk);
        req_op1 = 32'd20;
        req_op2 = 32'd6;
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL b2b_drain_stall got %0b exp 1", stall_o); end
        checks++; if (div_op1_o !== 32'd10) begin errors++; $display("FAIL b2b_ops_stable got %0h exp a", div_op1_o); end
        @(negedge clk);
        div_ready_i = 1'b0;
        busy_wait(2, st);
        checks++; if (st !== 1 || div_op1_o !== 32'd20 || div_op2_o !== 32'd6) begin errors++; $display("FAIL b2b_second_start got starts=%0d op1=%0h op2=%0h exp 1 14 6", st, div_op1_o, div_op2_o); end
        busy_wait(2, st);
        div_ready_i  = 1'b1;
        div_result_i = {32'd2, 32'd3};
        @(negedge clk);
        req_valid   = 1'b0;
        div_ready_i = 1'b0;
        #1;
        checks++; if (lo_o !== 32'd3 || hi_o !== 32'd2) begin errors++; $display("FAIL b2b_hilo got hi=%0h lo=%0h exp 2 3", hi_o, lo_o); end
        @(negedge clk);
        #2;
        checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", done_cnt - d0); end
    endtask

    initial begin
        test_reset();
        test_divu();
        test_divzero();
        test_signed();
        test_flush();
        test_timeout();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_hilo_div_ctrl
`default_nettype wire
